// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle for mux_rr_pipe: N input channels, one registered output.
// Dout_par exists only when MUX_RR_PIPE_PARITY_EN is defined.
interface mux_rr_pipe_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] Din;
    logic [NCH-1:0]       Din_vld;
    logic [NCH-1:0]       Din_rdy;
    logic                 Mode;
    logic [SELW-1:0]      Sel;
    logic [WIDTH-1:0]     Dout;
    logic                 Dout_vld;
    logic                 Dout_rdy;
    logic [SELW-1:0]      Dout_ch;
`ifdef MUX_RR_PIPE_PARITY_EN
    logic                 Dout_par;

    modport master (
        output Din, Din_vld, Mode, Sel, Dout_rdy,
        input  Din_rdy, Dout, Dout_vld, Dout_ch, Dout_par
    );

    modport slave (
        input  Din, Din_vld, Mode, Sel, Dout_rdy,
        output Din_rdy, Dout, Dout_vld, Dout_ch, Dout_par
    );
`else
    modport master (
        output Din, Din_vld, Mode, Sel, Dout_rdy,
        input  Din_rdy, Dout, Dout_vld, Dout_ch
    );

    modport slave (
        input  Din, Din_vld, Mode, Sel, Dout_rdy,
        output Din_rdy, Dout, Dout_vld, Dout_ch
    );
`endif
endinterface

// File: rtl/mux_rr_pipe.sv
// N-channel registered mux with fixed-select or round-robin arbitration.
// Optional output parity bit enabled by defining MUX_RR_PIPE_PARITY_EN.
module mux_rr_pipe #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_pipe_if.slave  bus
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic [SELW-1:0]  dout_ch_q, dout_ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
`ifdef MUX_RR_PIPE_PARITY_EN
    logic             dout_par_q, dout_par_d;
`endif

    logic             load_en;
    logic             fix_vld;
    logic             rr_vld;
    logic [SELW-1:0]  rr_gnt;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    assign load_en = !dout_vld_q || bus.Dout_rdy;

    // Fixed mode: only the selected channel may win; out-of-range Sel matches nothing.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.Sel == SELW'(k) && bus.Din_vld[k]) begin
                fix_vld = 1'b1;
            end
        end
    end

    // Scan from the farthest offset down so the nearest valid channel after ptr wins.
    always_comb begin
        int idx;
        rr_vld = 1'b0;
        rr_gnt = '0;
        idx    = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NCH;
            if (bus.Din_vld[idx]) begin
                rr_vld = 1'b1;
                rr_gnt = SELW'(idx);
            end
        end
    end

    assign gnt_vld = bus.Mode ? rr_vld : fix_vld;
    assign gnt     = bus.Mode ? rr_gnt : bus.Sel;
    assign xfer    = gnt_vld && load_en;

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt == SELW'(k)) begin
                gnt_data = bus.Din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.Din_rdy = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.Din_rdy[k] = xfer && !rst && (gnt == SELW'(k));
        end
    end

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        dout_ch_d  = dout_ch_q;
        ptr_d      = ptr_q;
`ifdef MUX_RR_PIPE_PARITY_EN
        dout_par_d = dout_par_q;
`endif
        if (xfer) begin
            dout_d     = gnt_data;
            dout_vld_d = 1'b1;
            dout_ch_d  = gnt;
            ptr_d      = (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);
`ifdef MUX_RR_PIPE_PARITY_EN
            dout_par_d = ^gnt_data;
`endif
        end else if (load_en) begin
            // Empty slot: drop valid but keep the last data/channel visible.
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_ch_q  <= '0;
            ptr_q      <= '0;
`ifdef MUX_RR_PIPE_PARITY_EN
            dout_par_q <= 1'b0;
`endif
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_ch_q  <= dout_ch_d;
            ptr_q      <= ptr_d;
`ifdef MUX_RR_PIPE_PARITY_EN
            dout_par_q <= dout_par_d;
`endif
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.Dout_vld = dout_vld_q;
    assign bus.Dout_ch  = dout_ch_q;
`ifdef MUX_RR_PIPE_PARITY_EN
    assign bus.Dout_par = dout_par_q;
`endif

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe: literal checkpoints plus a per-cycle model compare.
module tb_mux_rr_pipe;
    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mux_rr_pipe_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

    mux_rr_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the channel that wins this cycle, -1 when nobody does.
    function automatic int pick(input logic mode, input logic [SELW-1:0] sel,
                                input logic [NCH-1:0] vld, input int ptr);
        int order[$];
        if (!mode) return (int'(sel) < NCH && vld[sel]) ? int'(sel) : -1;
        for (int n = 0; n < NCH; n++) order.push_back((ptr + n) % NCH);
        foreach (order[j]) if (vld[order[j]]) return order[j];
        return -1;
    endfunction

    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic [SELW-1:0]  m_ch;
    int               m_ptr;
    int               g_now;
    logic [NCH-1:0]   m_rdy;
`ifdef MUX_RR_PIPE_PARITY_EN
    logic             m_par;
`endif

    assign g_now = pick(bus.Mode, bus.Sel, bus.Din_vld, m_ptr);
    assign m_rdy = (g_now >= 0 && (!m_vld || bus.Dout_rdy) && !rst) ? NCH'(1) << g_now : '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dout <= '0;
            m_vld  <= 1'b0;
            m_ch   <= '0;
            m_ptr  <= 0;
`ifdef MUX_RR_PIPE_PARITY_EN
            m_par  <= 1'b0;
`endif
        end else if (!m_vld || bus.Dout_rdy) begin
            if (g_now >= 0) begin
                m_dout <= bus.Din[g_now*WIDTH +: WIDTH];
                m_ch   <= SELW'(g_now);
                m_vld  <= 1'b1;
                m_ptr  <= (g_now + 1) % NCH;
`ifdef MUX_RR_PIPE_PARITY_EN
                m_par  <= ^bus.Din[g_now*WIDTH +: WIDTH];
`endif
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_din_rdy", 32'(bus.Din_rdy), 32'(m_rdy));
            chk("model_dout_vld", 32'(bus.Dout_vld), 32'(m_vld));
            chk("model_dout", 32'(bus.Dout), 32'(m_dout));
            chk("model_dout_ch", 32'(bus.Dout_ch), 32'(m_ch));
`ifdef MUX_RR_PIPE_PARITY_EN
            chk("model_dout_par", 32'(bus.Dout_par), 32'(m_par));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic           mode;
        logic [SELW-1:0] sel;
        logic [NCH-1:0] vld;
        logic           rdy;
    } vec_t;

    vec_t tbl[10];
    logic [3:0] rr_ch[5];
    logic [3:0] rr_dat[5];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.Din = '0; bus.Din_vld = '0; bus.Mode = 1'b0; bus.Sel = '0; bus.Dout_rdy = 1'b0;
        #12 rst = 1'b0;

        // Test 1: load 7 into the output, then assert reset mid-cycle.
        bus.Mode = 1'b0; bus.Sel = 2'd0; bus.Din = 16'h0007; bus.Din_vld = 4'b0001; bus.Dout_rdy = 1'b1;
        step();
        chk("t1_loaded_dout", 32'(bus.Dout), 32'h7);
        chk("t1_loaded_vld", 32'(bus.Dout_vld), 32'h1);
        bus.Dout_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_dout", 32'(bus.Dout), 32'h0);
        chk("t1_rst_vld", 32'(bus.Dout_vld), 32'h0);
        chk("t1_rst_ch", 32'(bus.Dout_ch), 32'h0);
        chk("t1_rst_din_rdy", 32'(bus.Din_rdy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Test 2: fixed select of channel 2.
        bus.Mode = 1'b0; bus.Sel = 2'd2; bus.Din = 16'h0A00; bus.Din_vld = 4'b0100; bus.Dout_rdy = 1'b1;
        #1;
        chk("t2_din_rdy", 32'(bus.Din_rdy), 32'b0100);
        step();
        chk("t2_dout", 32'(bus.Dout), 32'hA);
        chk("t2_ch", 32'(bus.Dout_ch), 32'd2);
        chk("t2_vld", 32'(bus.Dout_vld), 32'h1);

        // Test 3: round-robin over four always-valid channels from a fresh pointer.
        pulse_reset();
        bus.Mode = 1'b1; bus.Din = 16'h4321; bus.Din_vld = 4'b1111; bus.Dout_rdy = 1'b1;
        rr_ch  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        rr_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3_ch%0d", i), 32'(bus.Dout_ch), 32'(rr_ch[i]));
            chk($sformatf("t3_dout%0d", i), 32'(bus.Dout), 32'(rr_dat[i]));
        end

        // Test 4: three cycles of backpressure, then release.
        bus.Dout_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_stall_rdy%0d", i), 32'(bus.Din_rdy), 32'h0);
            chk($sformatf("t4_stall_dout%0d", i), 32'(bus.Dout), 32'h1);
            chk($sformatf("t4_stall_ch%0d", i), 32'(bus.Dout_ch), 32'h0);
            chk($sformatf("t4_stall_vld%0d", i), 32'(bus.Dout_vld), 32'h1);
            step();
        end
        bus.Dout_rdy = 1'b1;
        #1;
        chk("t4_release_rdy", 32'(bus.Din_rdy), 32'b0010);
        step();
        chk("t4_next_ch", 32'(bus.Dout_ch), 32'd1);
        chk("t4_next_dout", 32'(bus.Dout), 32'h2);

        // Test 5: pointer now 2; sparse valid set wraps 3 -> 1 -> 3.
        bus.Din = 16'h8765; bus.Din_vld = 4'b1010;
        step();
        chk("t5_ch_a", 32'(bus.Dout_ch), 32'd3);
        chk("t5_dout_a", 32'(bus.Dout), 32'h8);
        step();
        chk("t5_ch_b", 32'(bus.Dout_ch), 32'd1);
        chk("t5_dout_b", 32'(bus.Dout), 32'h6);
        step();
        chk("t5_ch_c", 32'(bus.Dout_ch), 32'd3);
        chk("t5_dout_c", 32'(bus.Dout), 32'h8);

        // Test 6: fixed select of an idle channel while another is valid.
        bus.Mode = 1'b0; bus.Sel = 2'd1; bus.Din_vld = 4'b0001;
        #1;
        chk("t6_din_rdy", 32'(bus.Din_rdy), 32'h0);
        step();
        chk("t6_vld", 32'(bus.Dout_vld), 32'h0);
        chk("t6_dout_hold", 32'(bus.Dout), 32'h8);
        chk("t6_ch_hold", 32'(bus.Dout_ch), 32'd3);

        // Mixed mode/backpressure sequence checked by the model only.
        bus.Din = 16'hC3A5;
        tbl[0] = '{1'b1, 2'd0, 4'b0110, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 4'b0110, 1'b0};
        tbl[2] = '{1'b0, 2'd3, 4'b1001, 1'b0};
        tbl[3] = '{1'b0, 2'd3, 4'b1001, 1'b1};
        tbl[4] = '{1'b1, 2'd1, 4'b0001, 1'b1};
        tbl[5] = '{1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[6] = '{1'b0, 2'd2, 4'b1111, 1'b1};
        tbl[7] = '{1'b1, 2'd2, 4'b1100, 1'b1};
        tbl[8] = '{1'b1, 2'd2, 4'b1100, 1'b1};
        tbl[9] = '{1'b1, 2'd2, 4'b1100, 1'b0};
        foreach (tbl[i]) begin
            bus.Mode = tbl[i].mode; bus.Sel = tbl[i].sel;
            bus.Din_vld = tbl[i].vld; bus.Dout_rdy = tbl[i].rdy;
            step();
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
